// File: rtl/dcache_read_ctrl_pkg.sv
// Shared definitions for the data-cache read controller: address field
// positions, widths and the controller state encoding.
package dcache_pkg;

  localparam int ADDR_W          = 15;
  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int BLOCK_W         = WORDS_PER_BLOCK * WORD_W;

  localparam int TAG_HI = 14;
  localparam int TAG_LO = 12;
  localparam int IDX_HI = 11;
  localparam int IDX_LO = 2;
  localparam int OFF_HI = 1;
  localparam int OFF_LO = 0;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    FILL,
    WRITE,
    RESPOND
  } state_e;

endpackage

// File: rtl/dcache_read_ctrl_if.sv
// Bundle of the CPU load port, cache port, memory port and performance
// counters. The controller sits on the master side; CPU, cache and memory
// models sit on the slave side.
interface dcache_read_ctrl_if
  import dcache_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic                 cpu_req;
  logic [ADDR_W-1:0]    cpu_address;
  logic                 cpu_ready;
  logic [WORD_W-1:0]    cpu_data;

  logic [ADDR_W-1:0]    cache_address;
  logic                 cache_read_enable;
  logic                 cache_write_enable;
  logic [BLOCK_W-1:0]   cache_block;
  logic                 cache_hit;
  logic [WORD_W-1:0]    cache_word;

  logic                 mem_read;
  logic [ADDR_W-1:0]    mem_address;
  logic                 mem_valid;
  logic [WORD_W-1:0]    mem_rdata;

  logic [CNT_W-1:0]     hit_count;
  logic [CNT_W-1:0]     miss_count;

  modport master (
    input  cpu_req, cpu_address, cache_hit, cache_word, mem_valid, mem_rdata,
    output cpu_ready, cpu_data, cache_address, cache_read_enable,
           cache_write_enable, cache_block, mem_read, mem_address,
           hit_count, miss_count
  );

  modport slave (
    output cpu_req, cpu_address, cache_hit, cache_word, mem_valid, mem_rdata,
    input  cpu_ready, cpu_data, cache_address, cache_read_enable,
           cache_write_enable, cache_block, mem_read, mem_address,
           hit_count, miss_count
  );

endinterface

// File: rtl/dcache_read_ctrl_sat_counter.sv
// Saturating up-counter used for the hit and miss statistics; it sticks at
// all-ones instead of wrapping so long runs never report a small count.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_q;

  // Count one event per cycle unless already saturated.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + ONE;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/dcache_read_ctrl.sv
// Read-path controller: looks a load up in the direct-mapped cache, and on a
// miss fetches the 4-word block from memory beat by beat, writes it into the
// cache in one strobe and returns the requested word to the CPU.
module dcache_read_ctrl
  import dcache_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  dcache_read_ctrl_if.master bus
);

  state_e                                    state_q, state_d;
  logic [ADDR_W-1:0]                         reqAddr_q, reqAddr_d;
  logic [1:0]                                beat_q, beat_d;
  logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0]    fillBuf_q, fillBuf_d;
  logic [WORD_W-1:0]                         cpuData_q, cpuData_d;
  logic                                      hitInc, missInc;

  // State, request address, fill buffer and response word registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      reqAddr_q <= '0;
      beat_q    <= '0;
      fillBuf_q <= '0;
      cpuData_q <= '0;
    end else begin
      state_q   <= state_d;
      reqAddr_q <= reqAddr_d;
      beat_q    <= beat_d;
      fillBuf_q <= fillBuf_d;
      cpuData_q <= cpuData_d;
    end
  end

  // Next-state logic; requests arriving outside IDLE are dropped.
  always_comb begin
    state_d   = state_q;
    reqAddr_d = reqAddr_q;
    beat_d    = beat_q;
    fillBuf_d = fillBuf_q;
    cpuData_d = cpuData_q;
    hitInc    = 1'b0;
    missInc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          reqAddr_d = bus.cpu_address;
          state_d   = LOOKUP;
        end
      end
      LOOKUP: begin
        if (bus.cache_hit) begin
          cpuData_d = bus.cache_word;
          hitInc    = 1'b1;
          state_d   = RESPOND;
        end else begin
          missInc = 1'b1;
          beat_d  = 2'd0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (bus.mem_valid) begin
          fillBuf_d[beat_q] = bus.mem_rdata;
          if (beat_q == 2'd3) begin
            state_d = WRITE;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
      end
      WRITE: begin
        cpuData_d = fillBuf_q[reqAddr_q[OFF_HI:OFF_LO]];
        state_d   = RESPOND;
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus outputs decoded from the current state so they are zero in reset.
  always_comb begin
    bus.cpu_ready          = (state_q == RESPOND);
    bus.cpu_data           = cpuData_q;
    bus.cache_address      = (state_q != IDLE) ? reqAddr_q : '0;
    bus.cache_read_enable  = (state_q == LOOKUP);
    bus.cache_write_enable = (state_q == WRITE);
    bus.cache_block        = (state_q == WRITE) ? fillBuf_q : '0;
    bus.mem_read           = (state_q == FILL);
    bus.mem_address        = (state_q == FILL) ? {reqAddr_q[ADDR_W-1:2], beat_q} : '0;
  end

  sat_counter #(.CNT_W(CNT_W)) hitCounter (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (hitInc),
    .count_o (bus.hit_count)
  );

  sat_counter #(.CNT_W(CNT_W)) missCounter (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (missInc),
    .count_o (bus.miss_count)
  );

endmodule

// File: tb/tb_dcache_read_ctrl.sv
// Bench for the cache read controller: a behavioural cache and memory, a
// response scoreboard (data + latency) and a fill-block scoreboard.
module tb_dcache_read_ctrl;
  import dcache_pkg::*;

  localparam int CNT_W  = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [31:0] data;
    int          lat;
  } resp_t;

  logic clk;
  logic rst;

  dcache_read_ctrl_if #(.CNT_W(CNT_W)) bus ();

  dcache_read_ctrl #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  resp_t        respQ[$];
  logic [127:0] blockQ[$];

  int          cycle = 0;
  int          reqCycle = 0;
  int          respCount = 0;
  int          writeCount = 0;
  int          memReadCycles = 0;
  int          exclViol = 0;
  int          memWait = 0;
  logic [31:0] memBase = 32'h0;
  logic [14:0] expBase = 15'h0;
  bit          strayValid = 1'b0;
  int          waitCnt = 0;
  int          beatIdx = 0;
  int          hitModel = 0;
  int          missModel = 0;

  bit          lineValid [1024];
  logic [2:0]  lineTag   [1024];
  logic [127:0] lineData [1024];

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Cycle counter used to measure response latency.
  always @(posedge clk) cycle <= cycle + 1;

  // Cache model: combinational hit/word lookup on cache_address.
  always_comb begin
    int idx;
    int off;
    idx = int'(bus.cache_address[11:2]);
    off = int'(bus.cache_address[1:0]);
    bus.cache_hit  = lineValid[idx] && (lineTag[idx] == bus.cache_address[14:12]);
    bus.cache_word = lineData[idx][off*32 +: 32];
  end

  // Cache model: block writes land on the clock edge.
  always @(posedge clk) begin
    if (bus.cache_write_enable) begin
      lineValid[int'(bus.cache_address[11:2])] <= 1'b1;
      lineTag[int'(bus.cache_address[11:2])]   <= bus.cache_address[14:12];
      lineData[int'(bus.cache_address[11:2])]  <= bus.cache_block;
    end
  end

  // Memory model: each beat is answered after memWait idle cycles.
  always @(negedge clk) begin
    if (bus.mem_read) begin
      memReadCycles++;
      if (waitCnt >= memWait) begin
        checkOutput("memAddr", {113'h0, bus.mem_address},
                    {113'h0, expBase[14:2], beatIdx[1:0]});
        bus.mem_valid = 1'b1;
        bus.mem_rdata = memBase + {30'h0, bus.mem_address[1:0]};
        beatIdx++;
        waitCnt = 0;
      end else begin
        bus.mem_valid = 1'b0;
        waitCnt++;
      end
    end else begin
      bus.mem_valid = strayValid;
      bus.mem_rdata = 32'hDEAD_0000;
      waitCnt = 0;
      beatIdx = 0;
    end
  end

  // Response and cache-write monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.cache_read_enable && bus.cache_write_enable) exclViol++;
    if (bus.cache_write_enable) begin
      writeCount++;
      if (blockQ.size() == 0) begin
        checkOutput("unexpWrite", 1, 0);
      end else begin
        checkOutput("cacheBlock", bus.cache_block, blockQ.pop_front());
        checkOutput("writeAddr", {113'h0, bus.cache_address}, {113'h0, expBase});
      end
    end
    if (bus.cpu_ready) begin
      resp_t r;
      respCount++;
      if (respQ.size() == 0) begin
        checkOutput("unexpReady", 1, 0);
      end else begin
        r = respQ.pop_front();
        checkOutput("cpuData", {96'h0, bus.cpu_data}, {96'h0, r.data});
        checkOutput("latency", cycle - reqCycle + 1, r.lat);
      end
    end
  end

  // One load; expectations are pushed before the request is sampled.
  task automatic applyStimulus(input logic [14:0] addr, input bit isMiss,
                               input logic [31:0] expData, input int expLat,
                               input int waitCycles, input logic [31:0] base);
    resp_t r;
    int startResp;
    int startMemRd;
    int guard;
    memWait = waitCycles;
    memBase = base;
    @(negedge clk);
    expBase = addr;
    r.data  = expData;
    r.lat   = expLat;
    respQ.push_back(r);
    if (isMiss) blockQ.push_back({base + 32'd3, base + 32'd2, base + 32'd1, base});
    startResp  = respCount;
    startMemRd = memReadCycles;
    bus.cpu_req     = 1'b1;
    bus.cpu_address = addr;
    @(posedge clk);
    #1 reqCycle = cycle;
    @(negedge clk);
    bus.cpu_req     = 1'b0;
    bus.cpu_address = ~addr;
    guard = 0;
    while (respCount == startResp && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("respTimeout", 0, 1);
    if (isMiss) missModel = (missModel < CNT_MAX) ? missModel + 1 : CNT_MAX;
    else        hitModel  = (hitModel  < CNT_MAX) ? hitModel + 1  : CNT_MAX;
    if (!isMiss) checkOutput("hitNoMemRead", memReadCycles - startMemRd, 0);
    checkOutput("hitCount",  {126'h0, bus.hit_count},  hitModel);
    checkOutput("missCount", {126'h0, bus.miss_count}, missModel);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    int writesBefore;
    int respBefore;
    rst             = 1'b1;
    bus.cpu_req     = 1'b0;
    bus.cpu_address = '0;

    // Reset for two cycles with stray memory-valid pulses.
    @(negedge clk);
    strayValid = 1'b1;
    @(negedge clk);
    checkOutput("rstCpuReady",  {127'h0, bus.cpu_ready}, 0);
    checkOutput("rstCpuData",   {96'h0, bus.cpu_data}, 0);
    checkOutput("rstCacheAddr", {113'h0, bus.cache_address}, 0);
    checkOutput("rstCacheRd",   {127'h0, bus.cache_read_enable}, 0);
    checkOutput("rstCacheWr",   {127'h0, bus.cache_write_enable}, 0);
    checkOutput("rstCacheBlk",  bus.cache_block, 0);
    checkOutput("rstMemRead",   {127'h0, bus.mem_read}, 0);
    checkOutput("rstMemAddr",   {113'h0, bus.mem_address}, 0);
    checkOutput("rstHitCount",  {126'h0, bus.hit_count}, 0);
    checkOutput("rstMissCount", {126'h0, bus.miss_count}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    strayValid = 1'b0;
    checkOutput("strayMemRead", memReadCycles, 0);
    checkOutput("idleState", {125'h0, dut.state_q}, {125'h0, IDLE});

    // Cold miss, zero-wait memory.
    applyStimulus(15'h1234, 1'b1, 32'hA2 - 32'd2, 7, 0, 32'hA0);
    // Hit in the freshly filled block.
    applyStimulus(15'h1236, 1'b0, 32'hA2, 2, 0, 32'hA0);
    // Conflict miss on the same index with 3 wait cycles per beat.
    applyStimulus(15'h2236, 1'b1, 32'hB2, 19, 3, 32'hB0);

    // Reset in the middle of a fill.
    memWait = 0;
    memBase = 32'hC0;
    writesBefore = writeCount;
    respBefore   = respCount;
    @(negedge clk);
    expBase         = 15'h3011;
    bus.cpu_req     = 1'b1;
    bus.cpu_address = 15'h3011;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    guard = 0;
    while (beatIdx < 2 && guard < 50) begin
      @(posedge clk);
      #1 guard++;
    end
    if (guard >= 50) checkOutput("fillTimeout", 0, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hitModel  = 0;
    missModel = 0;
    repeat (4) @(negedge clk);
    checkOutput("abortNoWrite", writeCount - writesBefore, 0);
    checkOutput("abortNoReady", respCount - respBefore, 0);
    checkOutput("abortHitCnt",  {126'h0, bus.hit_count}, 0);
    checkOutput("abortMissCnt", {126'h0, bus.miss_count}, 0);
    checkOutput("abortState",   {125'h0, dut.state_q}, {125'h0, IDLE});
    // Refetch restarts at beat 0.
    applyStimulus(15'h3011, 1'b1, 32'hC1, 7, 0, 32'hC0);

    // Five hits saturate the 2-bit hit counter at 3.
    for (int i = 0; i < 5; i++) begin
      logic [14:0] a;
      a = 15'h3010 + 15'(i % 4);
      applyStimulus(a, 1'b0, 32'hC0 + 32'(i % 4), 2, 0, 32'hC0);
    end

    repeat (2) @(negedge clk);
    checkOutput("rdWrExclusive", exclViol, 0);
    checkOutput("respQEmpty", respQ.size(), 0);
    checkOutput("blockQEmpty", blockQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
